// File: rtl/fifo_flex.sv
// Single-clock FIFO with full power-of-two capacity, selectable standard/FWFT read,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_flex #(
    parameter int BITS       = 16,
    parameter int DEPTH_LOG2 = 7,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (2 ** DEPTH_LOG2) - 4,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BITS-1:0]       wr_data,
    input  logic                  rd_en,
    output logic [BITS-1:0]       rd_data,
    output logic                  rd_valid,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL) begin : g_bad_param
            $fatal(1, "fifo_flex: AF_LEVEL/AE_LEVEL out of range");
        end
    endgenerate

    logic [BITS-1:0] r_mem [DEPTH];
    logic [CW-1:0]   r_wr_ptr, r_rd_ptr;
    logic            r_empty, r_full, r_ae, r_af, r_ovf, r_unf;
    logic            w_wr_acc, w_rd_acc;
    logic [CW-1:0]   w_fill, w_fill_nxt;

    // Pointer MSB disambiguates full from empty, so the difference is the exact fill.
    assign w_fill     = r_wr_ptr - r_rd_ptr;
    assign w_wr_acc   = wr_en & ~r_full;
    assign w_rd_acc   = rd_en & ~r_empty;
    assign w_fill_nxt = w_fill + CW'(w_wr_acc) - CW'(w_rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ae     <= 1'b1;
            r_af     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_empty <= (w_fill_nxt == '0);
            r_full  <= (w_fill_nxt == C_DEPTH);
            r_ae    <= (w_fill_nxt <= C_AE);
            r_af    <= (w_fill_nxt >= C_AF);
            // A fresh error at the same edge as clr_err keeps the flag set.
            r_ovf   <= (r_ovf & ~clr_err) | (wr_en & r_full);
            r_unf   <= (r_unf & ~clr_err) | (rd_en & r_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr[CW-2:0]] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Gate with empty so stale array contents never show after reset.
            assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr[CW-2:0]];
            assign rd_valid = ~r_empty;
        end else begin : g_std
            logic [BITS-1:0] r_rd_data;
            logic            r_rd_valid;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[CW-2:0]];
                end
            end
            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign fifo_empty   = r_empty;
    assign fifo_full    = r_full;
    assign almost_empty = r_ae;
    assign almost_full  = r_af;
    assign fill         = w_fill;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_flex.sv
// Randomized + directed bench for fifo_flex: one standard and one FWFT instance share stimulus
// and are compared against a queue-based reference model and a read-data scoreboard.
module tb_fifo_flex;

    localparam int BITS = 8;
    localparam int DL2  = 3;
    localparam int DEP  = 8;
    localparam int AF   = 6;
    localparam int AE   = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en, rd_en, clr_err;
    logic [BITS-1:0] wr_data;

    logic [BITS-1:0] s_rd_data, f_rd_data;
    logic            s_rd_valid, f_rd_valid;
    logic            s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic            f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [DL2:0]    s_fill, f_fill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_flex #(.BITS(BITS), .DEPTH_LOG2(DL2), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .fifo_empty(s_empty), .fifo_full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .fill(s_fill), .overflow(s_ovf),
        .underflow(s_unf), .clr_err(clr_err));

    fifo_flex #(.BITS(BITS), .DEPTH_LOG2(DL2), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .fifo_empty(f_empty), .fifo_full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .fill(f_fill), .overflow(f_ovf),
        .underflow(f_unf), .clr_err(clr_err));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a plain queue, sticky errors as bits.
    logic [BITS-1:0] mq[$];
    logic [BITS-1:0] expq[$];
    bit              m_ovf, m_unf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            expq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (mq.size() == DEP);
            was_empty = (mq.size() == 0);
            if (rd_en && !was_empty) expq.push_back(mq.pop_front());
            if (wr_en && !was_full) mq.push_back(wr_data);
            m_ovf = (m_ovf && !clr_err) || (wr_en && was_full);
            m_unf = (m_unf && !clr_err) || (rd_en && was_empty);
        end
    end

    // Monitor: flags vs model each cycle; standard-mode data popped from the scoreboard on rd_valid.
    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("fill_std", int'(s_fill), n);
        chk("fill_fwft", int'(f_fill), n);
        chk("empty", int'({s_empty, f_empty}), (n == 0) ? 3 : 0);
        chk("full", int'({s_full, f_full}), (n == DEP) ? 3 : 0);
        chk("almost_empty", int'({s_ae, f_ae}), (n <= AE) ? 3 : 0);
        chk("almost_full", int'({s_af, f_af}), (n >= AF) ? 3 : 0);
        chk("overflow", int'({s_ovf, f_ovf}), m_ovf ? 3 : 0);
        chk("underflow", int'({s_unf, f_unf}), m_unf ? 3 : 0);
        if (s_rd_valid) begin
            if (expq.size() == 0) chk("spurious_rd_valid", 1, 0);
            else chk("rd_data_std", int'(s_rd_data), int'(expq.pop_front()));
        end
        chk("missing_rd_valid", expq.size(), 0);
        chk("rd_valid_fwft", int'(f_rd_valid), (n != 0) ? 1 : 0);
        if (n != 0) chk("rd_data_fwft", int'(f_rd_data), int'(mq[0]));
    end

    task automatic cyc(input bit w, input logic [BITS-1:0] d, input bit r, input bit c);
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        @(negedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
        @(negedge clk); @(negedge clk); #1;
        rst = 1'b0;

        // Fill, overflow, drain, underflow and clear
        for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'hFF, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 1);

        // Wrap-around
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 0);
            for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
        end

        // Simultaneous at fill 4, when full, when empty
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h60 + i), 0, 0);
        cyc(1, 8'hEE, 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h77, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 1);

        // Randomized phases biased toward filling or draining
        for (int p = 0; p < 40; p++) begin
            int pw;
            pw = (p % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 50; i++)
                cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) >= pw,
                    $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1, 1);

        // Asynchronous reset between edges at fill 5
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_fill", int'({s_fill, f_fill}), 0);
        chk("rst_empty", int'({s_empty, f_empty, s_ae, f_ae}), 4'hF);
        chk("rst_full", int'({s_full, f_full, s_af, f_af}), 0);
        chk("rst_err", int'({s_ovf, f_ovf, s_unf, f_unf}), 0);
        chk("rst_rd", int'({s_rd_valid, f_rd_valid}), 0);
        chk("rst_rd_data", int'({s_rd_data, f_rd_data}), 0);
        cyc(0, 8'h00, 0, 0);
        rst = 1'b0;
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
